// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_arb_pkg
//  Description : Shared types and defaults for the dual-master Wishbone BRAM
//                arbiter (FSM state encoding, default access wait count).
//  Contents    : state_t        - arbiter FSM state (IDLE, ACCESS, ACK)
//                DELAYS_DEFAULT - default number of BRAM access wait cycles
//  Revision    : 1.0 - initial release
// ============================================================================
package bram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ACK    = 2'd2
   } state_t;

   localparam int DELAYS_DEFAULT = 10;

endpackage : bram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester round-robin arbiter. Grant is combinational
//                from req; the priority pointer moves only when update is
//                strobed, so a stalled or aborted transfer does not rotate it.
//  Ports       : clk    in  clock
//                rst_n  in  asynchronous active-low reset (priority -> req[0])
//                req    in  [1:0] request vector
//                update in  advance pointer past the currently granted bit
//                grant  out [1:0] one-hot grant (0 when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant
);

   // High when requester 1 has priority on a tie.
   logic prio_m1;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_m1 ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   // After serving requester 0, priority passes to requester 1 and vice versa.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_m1 <= 1'b0;
      end else if (update && (grant != 2'b00)) begin
         prio_m1 <= grant[0];
      end
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/bram_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bram_wb_arbiter
//  Description : Shares one single-port BRAM between two Wishbone masters
//                (m0 = management core, m1 = UART/DMA). Round-robin grant,
//                fixed DELAYS-cycle access window, one-cycle ack.
//  Ports       : wb_clk_i, wb_rst_n          clock, async active-low reset
//                mN_cyc_i/stb_i/we_i/sel_i   master N request, write, lanes
//                mN_adr_i/dat_i              master N word address, wdata
//                mN_ack_o/dat_o              master N completion, read data
//                bram_en_o/we_o/adr_o/wdat_o BRAM strobe, lanes, addr, wdata
//                bram_rdat_i                 BRAM read data
//                busy_o                      FSM not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_wb_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DELAYS = DELAYS_DEFAULT
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [3:0]        m0_sel_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [31:0]       m0_dat_i,
   output logic              m0_ack_o,
   output logic [31:0]       m0_dat_o,
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [3:0]        m1_sel_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [31:0]       m1_dat_i,
   output logic              m1_ack_o,
   output logic [31:0]       m1_dat_o,
   output logic              bram_en_o,
   output logic [3:0]        bram_we_o,
   output logic [ADDR_W-1:0] bram_adr_o,
   output logic [31:0]       bram_wdat_o,
   input  logic [31:0]       bram_rdat_i,
   output logic              busy_o
);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  req;
   logic [1:0]  arb_req;
   logic [1:0]  grant;
   logic [1:0]  win_oh;
   logic        win_we;
   logic        win_cyc;
   logic [7:0]  cnt;

   assign req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
   assign win_cyc = win_oh[1] ? m1_cyc_i : m0_cyc_i;
   assign busy_o  = (state != IDLE);

   // Outside IDLE the arbiter only sees the current winner, so the grant
   // reported during ACK is that winner and the pointer steps past it.
   assign arb_req = (state == IDLE) ? req : win_oh;

   rr_arb2 u_rr_arb2 (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_n),
      .req    (arb_req),
      .update (state == ACK),
      .grant  (grant)
   );

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req != 2'b00) state_nxt = ACCESS;
         end
         ACCESS: begin
            // Winner abandoning the cycle takes precedence over completion.
            if (!win_cyc)          state_nxt = IDLE;
            else if (cnt == 8'd0)  state_nxt = ACK;
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         win_oh      <= 2'b00;
         win_we      <= 1'b0;
         cnt         <= 8'd0;
         bram_en_o   <= 1'b0;
         bram_we_o   <= 4'h0;
         bram_adr_o  <= '0;
         bram_wdat_o <= 32'h0;
         m0_ack_o    <= 1'b0;
         m1_ack_o    <= 1'b0;
         m0_dat_o    <= 32'h0;
         m1_dat_o    <= 32'h0;
      end else begin
         // Strobes and returned data are single-cycle pulses by default.
         bram_en_o <= 1'b0;
         bram_we_o <= 4'h0;
         m0_ack_o  <= 1'b0;
         m1_ack_o  <= 1'b0;
         m0_dat_o  <= 32'h0;
         m1_dat_o  <= 32'h0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  win_oh    <= grant;
                  cnt       <= 8'(DELAYS - 1);
                  bram_en_o <= 1'b1;
                  if (grant[1]) begin
                     win_we      <= m1_we_i;
                     bram_we_o   <= m1_we_i ? m1_sel_i : 4'h0;
                     bram_adr_o  <= m1_adr_i;
                     bram_wdat_o <= m1_dat_i;
                  end else begin
                     win_we      <= m0_we_i;
                     bram_we_o   <= m0_we_i ? m0_sel_i : 4'h0;
                     bram_adr_o  <= m0_adr_i;
                     bram_wdat_o <= m0_dat_i;
                  end
               end
            end
            ACCESS: begin
               if (cnt != 8'd0) cnt <= cnt - 8'd1;
               // Last access cycle: capture read data and raise the ack.
               if (state_nxt == ACK) begin
                  m0_ack_o <= win_oh[0];
                  m1_ack_o <= win_oh[1];
                  if (!win_we && win_oh[0]) m0_dat_o <= bram_rdat_i;
                  if (!win_we && win_oh[1]) m1_dat_o <= bram_rdat_i;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : bram_wb_arbiter
`default_nettype wire

// File: tb/tb_bram_wb_arbiter.sv
`timescale 1ns/1ps
module tb_bram_wb_arbiter;

   localparam int ADDR_W = 10;
   localparam int DELAYS = 10;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
   logic [3:0]        m0_sel = 4'h0;
   logic [ADDR_W-1:0] m0_adr = '0;
   logic [31:0]       m0_wd  = 32'h0;
   logic              m0_ack;
   logic [31:0]       m0_rd;
   logic              m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
   logic [3:0]        m1_sel = 4'h0;
   logic [ADDR_W-1:0] m1_adr = '0;
   logic [31:0]       m1_wd  = 32'h0;
   logic              m1_ack;
   logic [31:0]       m1_rd;
   logic              bram_en;
   logic [3:0]        bram_we;
   logic [ADDR_W-1:0] bram_adr;
   logic [31:0]       bram_wdat;
   logic [31:0]       bram_rdat = 32'h0;
   logic              busy;

   bram_wb_arbiter #(.ADDR_W(ADDR_W), .DELAYS(DELAYS)) dut (
      .wb_clk_i   (clk),      .wb_rst_n   (rst_n),
      .m0_cyc_i   (m0_cyc),   .m0_stb_i   (m0_stb),   .m0_we_i  (m0_we),
      .m0_sel_i   (m0_sel),   .m0_adr_i   (m0_adr),   .m0_dat_i (m0_wd),
      .m0_ack_o   (m0_ack),   .m0_dat_o   (m0_rd),
      .m1_cyc_i   (m1_cyc),   .m1_stb_i   (m1_stb),   .m1_we_i  (m1_we),
      .m1_sel_i   (m1_sel),   .m1_adr_i   (m1_adr),   .m1_dat_i (m1_wd),
      .m1_ack_o   (m1_ack),   .m1_dat_o   (m1_rd),
      .bram_en_o  (bram_en),  .bram_we_o  (bram_we),  .bram_adr_o (bram_adr),
      .bram_wdat_o(bram_wdat),.bram_rdat_i(bram_rdat),.busy_o   (busy)
   );

   always #5 clk = ~clk;

   // Behavioural single-port BRAM, one-cycle read latency, read-before-write.
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (bram_en) begin
         bram_rdat <= mem[bram_adr];
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_adr][8*b +: 8] = bram_wdat[8*b +: 8];
      end
   end

   int cycle_no = 0;
   always @(posedge clk) cycle_no <= cycle_no + 1;

   typedef struct { int m; logic [31:0] d; } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;
   int ack_cyc [2] = '{0, 0};
   bit ack_seen[2] = '{0, 0};
   int reissue [2] = '{0, 0};
   int nxt_adr [2] = '{0, 0};
   bit gap_on   = 1'b0;
   int prev_ack = 0;
   int t0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic req(input int m, input logic we, input int a, input logic [31:0] d,
                      input logic [3:0] s);
      ack_seen[m] = 1'b0;
      if (m == 0) begin
         m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = ADDR_W'(a); m0_wd = d; m0_sel = s;
      end else begin
         m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = ADDR_W'(a); m1_wd = d; m1_sel = s;
      end
   endtask

   task automatic drop(input int m);
      if (m == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; end
      else        begin m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; end
   endtask

   function automatic logic [31:0] pattern(input int a);
      return 32'hC0DE0000 | 32'(a);
   endfunction

   task automatic handle(input int m, input logic ack, input logic [31:0] dat);
      exp_t e;
      if (!ack) begin
         chk($sformatf("m%0d_dat_idle", m), dat, 32'h0);
         return;
      end
      ack_seen[m] = 1'b1;
      ack_cyc[m]  = cycle_no;
      if (gap_on && prev_ack > 0) chk("ack_gap", 32'(cycle_no - prev_ack), 32'd12);
      prev_ack = cycle_no;
      chk("ack_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("ack_master", 32'(m), 32'(e.m));
         chk("ack_data", dat, e.d);
      end
      drop(m);
      if (reissue[m] > 0) begin
         reissue[m]--;
         nxt_adr[m]++;
         req(m, 1'b0, nxt_adr[m], 32'h0, 4'h0);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
      chk("ack_overlap", 32'(m0_ack & m1_ack), 32'd0);
      handle(0, m0_ack, m0_rd);
      handle(1, m1_ack, m1_rd);
   endtask

   task automatic wait_ack(input int m, input int budget);
      for (int i = 0; i < budget && !ack_seen[m]; i++) tick();
      chk($sformatf("m%0d_ack_timeout", m), 32'(ack_seen[m]), 32'd1);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_en"},   32'(bram_en), 32'd0);
      chk({tag, "_we"},   32'(bram_we), 32'd0);
      chk({tag, "_adr"},  32'(bram_adr), 32'd0);
      chk({tag, "_wdat"}, bram_wdat, 32'h0);
      chk({tag, "_acks"}, 32'({m0_ack, m1_ack}), 32'd0);
      chk({tag, "_dat"},  m0_rd | m1_rd, 32'h0);
   endtask

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = pattern(a);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_quiet("reset");
      rst_n = 1'b1;
      tick();

      // Tie after reset: m0 first, m1 twelve cycles later
      t0 = cycle_no;
      sb.push_back('{0, pattern(5)});
      sb.push_back('{1, pattern(6)});
      req(0, 1'b0, 5, 32'h0, 4'h0);
      req(1, 1'b0, 6, 32'h0, 4'h0);
      wait_ack(1, 40);
      chk("tie_m0_lat", 32'(ack_cyc[0] - t0), 32'd11);
      chk("tie_m1_lat", 32'(ack_cyc[1] - t0), 32'd23);

      // m0 write then readback of 0xDEADBEEF at 0x010
      tick();
      t0 = cycle_no;
      sb.push_back('{0, 32'h0});
      req(0, 1'b1, 'h010, 32'hDEADBEEF, 4'hF);
      tick();
      chk("wr_en",   32'(bram_en), 32'd1);
      chk("wr_we",   32'(bram_we), 32'hF);
      chk("wr_adr",  32'(bram_adr), 32'h010);
      chk("wr_wdat", bram_wdat, 32'hDEADBEEF);
      chk("wr_busy", 32'(busy), 32'd1);
      tick();
      chk("en_one_cycle", 32'(bram_en), 32'd0);
      wait_ack(0, 20);
      chk("wr_lat", 32'(ack_cyc[0] - t0), 32'd11);
      tick();
      chk("busy_after_ack", 32'(busy), 32'd0);
      t0 = cycle_no;
      sb.push_back('{0, 32'hDEADBEEF});
      req(0, 1'b0, 'h010, 32'h0, 4'hF);
      tick();
      chk("rd_en", 32'(bram_en), 32'd1);
      chk("rd_we", 32'(bram_we), 32'd0);
      wait_ack(0, 20);
      chk("rd_lat", 32'(ack_cyc[0] - t0), 32'd11);

      // Byte-lane write through m1
      tick();
      sb.push_back('{1, 32'h0});
      req(1, 1'b1, 'h020, 32'h11223344, 4'hF);
      wait_ack(1, 20);
      tick();
      sb.push_back('{1, 32'h0});
      req(1, 1'b1, 'h020, 32'h0000AB00, 4'h2);
      wait_ack(1, 20);
      tick();
      sb.push_back('{1, 32'h1122AB44});
      req(1, 1'b0, 'h020, 32'h0, 4'h0);
      wait_ack(1, 20);

      // Continuous contention: strict alternation, 12-cycle spacing
      tick();
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{0, pattern('h100 + k)});
         sb.push_back('{1, pattern('h108 + k)});
      end
      nxt_adr[0] = 'h100; nxt_adr[1] = 'h108;
      reissue[0] = 2;     reissue[1] = 2;
      gap_on = 1'b1; prev_ack = 0;
      req(0, 1'b0, 'h100, 32'h0, 4'h0);
      req(1, 1'b0, 'h108, 32'h0, 4'h0);
      for (int i = 0; i < 120 && sb.size() != 0; i++) tick();
      chk("rr_all_done", 32'(sb.size()), 32'd0);
      gap_on = 1'b0;

      // m1 abandons its read; pending m0 is granted right after
      tick();
      t0 = cycle_no;
      req(1, 1'b0, 'h030, 32'h0, 4'h0);
      tick();
      sb.push_back('{0, pattern('h031)});
      req(0, 1'b0, 'h031, 32'h0, 4'h0);
      tick();
      tick();
      drop(1);
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      tick();
      chk("abort_next_en",  32'(bram_en), 32'd1);
      chk("abort_next_adr", 32'(bram_adr), 32'h031);
      wait_ack(0, 20);
      chk("abort_m0_lat", 32'(ack_cyc[0] - t0), 32'd15);
      chk("abort_no_m1_ack", 32'(ack_seen[1]), 32'd0);

      // Asynchronous reset in the middle of an access
      tick();
      req(0, 1'b0, 'h040, 32'h0, 4'h0);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk_quiet("midreset");
      drop(0);
      tick();
      rst_n = 1'b1;
      tick();
      t0 = cycle_no;
      sb.push_back('{1, pattern('h050)});
      req(1, 1'b0, 'h050, 32'h0, 4'h0);
      tick();
      chk("post_rst_en", 32'(bram_en), 32'd1);
      wait_ack(1, 20);
      chk("post_rst_lat", 32'(ack_cyc[1] - t0), 32'd11);
      chk("post_rst_no_m0_ack", 32'(ack_seen[0]), 32'd0);
      tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_wb_arbiter.md
BRAM_WB_ARBITER -- requirements
Module: bram_wb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM word-address width (4 KB).
REQ-002 Parameter DELAYS, default 10, BRAM access wait cycles; legal range 1..255.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 wb_rst_n  in  1  asynchronous, active-low reset.
REQ-005 m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  requester 0 (management-core Wishbone) cycle, strobe, write.
REQ-006 m0_sel_i  in  4  byte lanes; m0_adr_i in ADDR_W word address; m0_dat_i in 32 write data.
REQ-007 m0_ack_o  out  1  one-cycle completion; m0_dat_o out 32 read data.
REQ-008 m1_* ports identical to REQ-005..007 for requester 1 (UART/DMA engine).
REQ-009 bram_en_o out 1, bram_we_o out 4, bram_adr_o out ADDR_W, bram_wdat_o out 32, bram_rdat_i in 32: single-port BRAM.
REQ-010 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-011 Request from master n SHALL be mn_cyc_i & mn_stb_i.
REQ-012 FSM states SHALL be IDLE, ACCESS, ACK.
REQ-013 In IDLE with at least one request, the arbiter SHALL latch the winner, its adr/dat/sel/we, and go to ACCESS.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests, grant the master not granted last; after reset, m0 wins the first tie.
REQ-015 A sole requester SHALL win regardless of round-robin pointer.
REQ-016 In the first ACCESS cycle, bram_en_o SHALL be 1 for exactly one cycle, and bram_we_o SHALL equal latched sel on writes and 0 on reads.
REQ-017 A wait counter SHALL load DELAYS-1 on entry to ACCESS and decrement each cycle; at 0, the FSM SHALL go to ACK.
REQ-018 On a read, bram_rdat_i SHALL be captured in the last ACCESS cycle and held on the winner's dat_o through ACK.
REQ-019 In ACK, the winner's ack_o SHALL be 1 for exactly one cycle, the loser's ack_o SHALL be 0, and the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be: request sampled in cycle T, bram_en_o in T+1, ack_o in T+1+DELAYS; the next grant is no earlier than T+2+DELAYS.
REQ-021 If the winner drops cyc_i during ACCESS, the FSM SHALL go to IDLE next cycle without ack; an already-issued write stands.
REQ-022 The non-granted master SHALL be stalled (ack 0) until granted; its request is never lost while it holds cyc/stb.
REQ-023 The round-robin pointer SHALL update only on completed (acked) transactions.
REQ-024 mn_dat_o SHALL be 0 except for the winner's read data during ACK.

Reset
REQ-025 On wb_rst_n low, asynchronously: state IDLE, counter 0, pointer to m0, and all outputs (acks, dat_o, bram_*, busy_o) 0.
REQ-026 Reset asserted mid-ACCESS SHALL abort without ack; after release, the first request is handled as after power-up.

Structure
REQ-027 The FSM state enum and DELAYS default SHALL reside in shared package bram_arb_pkg.
REQ-028 The round-robin arbiter SHALL be a sub-module rr_arb2 (inputs req[1:0] and update strobe; output one-hot grant).

Verification
REQ-029 m0 writes 0xDEADBEEF to addr 0x010 with sel 0xF, then reads it back -> bram_en_o in T+1, m0_ack_o in T+11, read data 0xDEADBEEF.
REQ-030 m0 and m1 both request reads in the same cycle after reset -> m0 is acked first; m1 is acked 12 cycles later (DELAYS=10).
REQ-031 Both masters request continuously for 6 transactions -> grants alternate m0, m1, m0, ...; no ack overlap.
REQ-032 Byte write of sel 0x2 with data 0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
REQ-033 m1 drops cyc 3 cycles into a read -> no m1_ack_o, busy_o falls next cycle, pending m0 is then granted.
REQ-034 wb_rst_n pulsed low mid-ACCESS -> all outputs 0 immediately; the subsequent m1 request completes normally in 1+DELAYS cycles.
